// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared widths, port FSM states and request type for mem_responder
// Define MEM_RESPONDER_ERR_EN to turn on address range/alignment errors.
package mem_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BEN_W  = DATA_W / 8;

`ifdef MEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } port_state_e;

  typedef struct packed {
    logic              rnw;
    logic [BEN_W-1:0]  ben;
    logic [DATA_W-1:0] wdata;
    logic              err;
  } port_req_t;

  // off is the byte offset from ADDR_BASE; addresses below the base wrap to huge offsets
  function automatic logic addr_bad(input logic [ADDR_W-1:0] off, input logic [1:0] lsb,
                                    input int unsigned words);
    return (off >= ADDR_W'(4 * words)) || (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - CPU I-Port and D-Port bundle; core is master, responder is slave
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic [ADDR_W-1:0] i_IAddr;
  logic              i_IRdC;
  logic [DATA_W-1:0] o_IData;
  logic              o_IRdy;
  logic              o_IErr;

  logic [ADDR_W-1:0] i_DAddr;
  logic              i_DCmd;
  logic              i_DRnW;
  logic [BEN_W-1:0]  i_DBen;
  logic [DATA_W-1:0] i_DData;
  logic [DATA_W-1:0] o_DData;
  logic              o_DRdy;
  logic              o_DErr;

  modport master (
    output i_IAddr, i_IRdC, i_DAddr, i_DCmd, i_DRnW, i_DBen, i_DData,
    input  o_IData, o_IRdy, o_IErr, o_DData, o_DRdy, o_DErr
  );

  modport slave (
    input  i_IAddr, i_IRdC, i_DAddr, i_DCmd, i_DRnW, i_DBen, i_DData,
    output o_IData, o_IRdy, o_IErr, o_DData, o_DRdy, o_DErr
  );

endinterface

// File: rtl/mem_resp_port.sv
// rtl/mem_resp_port.sv - per-port request latch, wait-state counter and IDLE/WAIT/ACCESS/RESP FSM
module mem_resp_port
  import mem_responder_pkg::*;
#(
  parameter int unsigned       MEM_WORDS   = 4096,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
  parameter int unsigned       WAIT_STATES = 1,
  parameter bit                WR_EN       = 1'b1,
  localparam int unsigned      IDX_W       = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rnw_i,
  input  logic [BEN_W-1:0]  ben_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              grant_i,
  output logic              access_o,
  output logic [IDX_W-1:0]  idx_o,
  output port_req_t         req_o,
  output logic              rdy_o,
  output logic              err_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  port_state_e       state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  port_req_t         req_q, req_d;
  logic [ADDR_W-1:0] offset;

  assign offset = addr_i - ADDR_BASE;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE, ST_RESP: begin
        if (state_q == ST_RESP) state_d = ST_IDLE;
        // RESP accepts a new command exactly like IDLE so requests can run back-to-back
        if (cmd_i) begin
          state_d     = (WS != 4'd0) ? ST_WAIT : ST_ACCESS;
          cnt_d       = (WS != 4'd0) ? WS - 4'd1 : 4'd0;
          idx_d       = offset[IDX_W+1:2];
          req_d.rnw   = rnw_i | ~WR_EN;
          req_d.ben   = ben_i;
          req_d.wdata = wdata_i;
          req_d.err   = ERR_EN & addr_bad(offset, addr_i[1:0], MEM_WORDS);
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        if (grant_i) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign access_o = (state_q == ST_ACCESS);
  assign idx_o    = idx_q;
  assign req_o    = req_q;
  assign rdy_o    = (state_q == ST_RESP) & ~req_q.err;
  assign err_o    = (state_q == ST_RESP) &  req_q.err;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - on-chip memory terminating the CPU I-Port and D-Port
// Holds the word array, the single-slot arbiter (D has priority) and the read data registers.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned       MEM_WORDS   = 4096,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned       WAIT_STATES = 1,
  localparam int unsigned      IDX_W       = $clog2(MEM_WORDS)
) (
  input logic            clk,
  input logic            nrst,
  mem_responder_if.slave bus
);

  logic              i_access, d_access, i_grant, d_grant;
  logic [IDX_W-1:0]  i_idx, d_idx, sel_idx;
  port_req_t         i_req, d_req, sel_req;
  logic              slot_used, wr_fire, rd_fire;
  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic [DATA_W-1:0] i_data_q, d_data_q;

  mem_resp_port #(
    .MEM_WORDS(MEM_WORDS), .ADDR_BASE(ADDR_BASE), .WAIT_STATES(WAIT_STATES), .WR_EN(1'b0)
  ) u_iport (
    .clk(clk), .nrst(nrst),
    .cmd_i(bus.i_IRdC), .addr_i(bus.i_IAddr), .rnw_i(1'b1), .ben_i('0), .wdata_i('0),
    .grant_i(i_grant), .access_o(i_access), .idx_o(i_idx), .req_o(i_req),
    .rdy_o(bus.o_IRdy), .err_o(bus.o_IErr)
  );

  mem_resp_port #(
    .MEM_WORDS(MEM_WORDS), .ADDR_BASE(ADDR_BASE), .WAIT_STATES(WAIT_STATES), .WR_EN(1'b1)
  ) u_dport (
    .clk(clk), .nrst(nrst),
    .cmd_i(bus.i_DCmd), .addr_i(bus.i_DAddr), .rnw_i(bus.i_DRnW), .ben_i(bus.i_DBen),
    .wdata_i(bus.i_DData),
    .grant_i(d_grant), .access_o(d_access), .idx_o(d_idx), .req_o(d_req),
    .rdy_o(bus.o_DRdy), .err_o(bus.o_DErr)
  );

  // An erroring request still occupies the slot; it just never touches the array
  assign d_grant   = d_access;
  assign i_grant   = i_access & ~d_access;
  assign sel_idx   = d_access ? d_idx : i_idx;
  assign sel_req   = d_access ? d_req : i_req;
  assign slot_used = d_access | i_access;
  assign wr_fire   = slot_used & ~sel_req.err & ~sel_req.rnw;
  assign rd_fire   = slot_used & ~sel_req.err &  sel_req.rnw;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < BEN_W; b++) begin
        if (sel_req.ben[b]) mem_q[sel_idx][8*b +: 8] <= sel_req.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      i_data_q <= '0;
      d_data_q <= '0;
    end else if (rd_fire) begin
      if (d_access) d_data_q <= mem_q[sel_idx];
      else          i_data_q <= mem_q[sel_idx];
    end
  end

  assign bus.o_IData = i_data_q;
  assign bus.o_DData = d_data_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - two responders (0 and 1 wait states) on shared stimulus vs. a transaction-level model
module tb_mem_responder;

  localparam int          MW   = 256;
  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] t_iaddr, t_daddr, t_ddata;
  logic        t_irdc, t_dcmd, t_drnw;
  logic [3:0]  t_dben;

  mem_responder_if bus0();
  mem_responder_if bus1();

  assign bus0.i_IAddr = t_iaddr;  assign bus1.i_IAddr = t_iaddr;
  assign bus0.i_IRdC  = t_irdc;   assign bus1.i_IRdC  = t_irdc;
  assign bus0.i_DAddr = t_daddr;  assign bus1.i_DAddr = t_daddr;
  assign bus0.i_DCmd  = t_dcmd;   assign bus1.i_DCmd  = t_dcmd;
  assign bus0.i_DRnW  = t_drnw;   assign bus1.i_DRnW  = t_drnw;
  assign bus0.i_DBen  = t_dben;   assign bus1.i_DBen  = t_dben;
  assign bus0.i_DData = t_ddata;  assign bus1.i_DData = t_ddata;

  mem_responder #(.MEM_WORDS(MW), .ADDR_BASE(BASE), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nrst(nrst), .bus(bus0));
  mem_responder #(.MEM_WORDS(MW), .ADDR_BASE(BASE), .WAIT_STATES(1)) dut1 (
    .clk(clk), .nrst(nrst), .bus(bus1));

  logic [31:0] o_idata [2];
  logic [31:0] o_ddata [2];
  logic        o_irdy [2];
  logic        o_ierr [2];
  logic        o_drdy [2];
  logic        o_derr [2];
  assign o_idata[0] = bus0.o_IData;  assign o_idata[1] = bus1.o_IData;
  assign o_ddata[0] = bus0.o_DData;  assign o_ddata[1] = bus1.o_DData;
  assign o_irdy[0]  = bus0.o_IRdy;   assign o_irdy[1]  = bus1.o_IRdy;
  assign o_ierr[0]  = bus0.o_IErr;   assign o_ierr[1]  = bus1.o_IErr;
  assign o_drdy[0]  = bus0.o_DRdy;   assign o_drdy[1]  = bus1.o_DRdy;
  assign o_derr[0]  = bus0.o_DErr;   assign o_derr[1]  = bus1.o_DErr;

  typedef struct {
    int          cyc;
    bit          rd;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        dq [2][$];
  exp_t        iq [2][$];
  logic [31:0] mem_m [MW];
  logic [31:0] last_d [2];
  logic [31:0] last_i [2];
  int          d_rdy [2];
  int          i_rdy [2];
  int          d_acc [2];
  int          cyc, n_vec, n_err;

  function automatic int wsv(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic bit m_bad(input logic [31:0] a);
    logic [31:0] off;
    bit en;
`ifdef MEM_RESPONDER_ERR_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    off = a - BASE;
    return en && ((off >= 32'(4 * MW)) || (a[1:0] != 2'b00));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 2) & 32'(MW - 1));
  endfunction

  function automatic bit d_free();
    return (cyc >= d_rdy[0]) && (cyc >= d_rdy[1]);
  endfunction

  function automatic bit i_free();
    return (cyc >= i_rdy[0]) && (cyc >= i_rdy[1]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      dq[d].delete();
      iq[d].delete();
      last_d[d] = '0;
      last_i[d] = '0;
      d_rdy[d]  = 0;
      i_rdy[d]  = 0;
      d_acc[d]  = -1;
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      logic e_drdy, e_derr, e_irdy, e_ierr;
      e_drdy = 1'b0; e_derr = 1'b0; e_irdy = 1'b0; e_ierr = 1'b0;
      if (dq[d].size() != 0 && dq[d][0].cyc == cyc) begin
        e_drdy = !dq[d][0].err;
        e_derr = dq[d][0].err;
        if (dq[d][0].rd && !dq[d][0].err) last_d[d] = dq[d][0].data;
        void'(dq[d].pop_front());
      end
      if (iq[d].size() != 0 && iq[d][0].cyc == cyc) begin
        e_irdy = !iq[d][0].err;
        e_ierr = iq[d][0].err;
        if (!iq[d][0].err) last_i[d] = iq[d][0].data;
        void'(iq[d].pop_front());
      end
      check($sformatf("ws%0d drdy @%0d", wsv(d), cyc), o_drdy[d], e_drdy);
      check($sformatf("ws%0d derr @%0d", wsv(d), cyc), o_derr[d], e_derr);
      check($sformatf("ws%0d ddata @%0d", wsv(d), cyc), o_ddata[d], last_d[d]);
      check($sformatf("ws%0d irdy @%0d", wsv(d), cyc), o_irdy[d], e_irdy);
      check($sformatf("ws%0d ierr @%0d", wsv(d), cyc), o_ierr[d], e_ierr);
      check($sformatf("ws%0d idata @%0d", wsv(d), cyc), o_idata[d], last_i[d]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    t_dcmd = 1'b0;
    t_irdc = 1'b0;
    check_outputs();
  endtask

  task automatic wait_free(input bit need_d, input bit need_i);
    int n;
    n = 0;
    while (!((!need_d || d_free()) && (!need_i || i_free())) && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) check("wait_free timeout", 32'd1, 32'd0);
  endtask

  // Requests are applied in issue order, D before I: a later request never reaches the array first
  task automatic issue(input bit do_d, input bit rnw, input logic [31:0] da, input logic [3:0] ben,
                       input logic [31:0] wd, input bit do_i, input logic [31:0] ia, input bit track);
    exp_t e;
    int   acc, ix;
    t_dcmd = do_d; t_drnw = rnw; t_daddr = da; t_dben = ben; t_ddata = wd;
    t_irdc = do_i; t_iaddr = ia;
    if (!track) return;
    if (do_d) begin
      ix = m_idx(da);
      e.rd = rnw; e.err = m_bad(da); e.data = '0;
      if (!e.err) begin
        if (rnw) e.data = mem_m[ix];
        else for (int b = 0; b < 4; b++) if (ben[b]) mem_m[ix][8*b +: 8] = wd[8*b +: 8];
      end
      for (int d = 0; d < 2; d++) begin
        acc = cyc + 1 + wsv(d);
        e.cyc = acc + 1;
        dq[d].push_back(e);
        d_rdy[d] = e.cyc;
        d_acc[d] = acc;
      end
    end
    if (do_i) begin
      ix = m_idx(ia);
      e.rd = 1'b1; e.err = m_bad(ia);
      e.data = e.err ? 32'h0 : mem_m[ix];
      for (int d = 0; d < 2; d++) begin
        acc = cyc + 1 + wsv(d);
        if (acc == d_acc[d]) acc++;
        e.cyc = acc + 1;
        iq[d].push_back(e);
        i_rdy[d] = e.cyc;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 15);
    if (sel == 0) return BASE + 32'(4 * MW) + 32'(4 * $urandom_range(0, 7));
    if (sel == 1) return BASE - 32'd4;
    if (sel < 4)  return BASE + 32'($urandom_range(0, 63));
    return BASE + 32'(4 * $urandom_range(0, 15));
  endfunction

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    t_iaddr = '0; t_irdc = 1'b0; t_daddr = '0; t_dcmd = 1'b0;
    t_drnw = 1'b0; t_dben = '0; t_ddata = '0;
    model_reset();
    repeat (3) tick();
    nrst = 1'b1;

    for (int w = 0; w < MW; w++) begin
      wait_free(1, 0);
      issue(1, 0, BASE + 32'(4 * w), 4'hF, $urandom, 0, '0, 1);
      tick();
    end

    wait_free(1, 0); issue(1, 0, BASE + 32'h10, 4'hF, 32'hDEADBEEF, 0, '0, 1); tick();
    wait_free(1, 0); issue(1, 1, BASE + 32'h10, 4'hF, '0, 0, '0, 1); tick();
    wait_free(1, 0);
    check("deadbeef ws0", o_ddata[0], 32'hDEADBEEF);
    check("deadbeef ws1", o_ddata[1], 32'hDEADBEEF);

    wait_free(1, 0); issue(1, 0, BASE + 32'h20, 4'hF, 32'hAABBCCDD, 0, '0, 1); tick();
    wait_free(1, 0); issue(1, 0, BASE + 32'h20, 4'b0101, 32'h11223344, 0, '0, 1); tick();
    wait_free(1, 0); issue(1, 0, BASE + 32'h20, 4'b0000, 32'h55667788, 0, '0, 1); tick();
    wait_free(1, 0); issue(1, 1, BASE + 32'h20, 4'h0, '0, 0, '0, 1); tick();
    wait_free(1, 0);
    check("partial ws0", o_ddata[0], 32'hAA22CC44);
    check("partial ws1", o_ddata[1], 32'hAA22CC44);

    wait_free(1, 1); issue(1, 1, BASE + 32'h10, 4'hF, '0, 1, BASE + 32'h20, 1); tick();
    wait_free(1, 1);
    check("dual d ws1", o_ddata[1], 32'hDEADBEEF);
    check("dual i ws1", o_idata[1], 32'hAA22CC44);

    for (int k = 0; k < 3; k++) begin
      wait_free(0, 1);
      issue(0, 1, '0, '0, '0, 1, BASE + 32'(4 * k), 1);
      tick();
    end

    wait_free(1, 0); issue(1, 1, BASE + 32'h2, 4'hF, '0, 0, '0, 1); tick();
    wait_free(1, 0); issue(1, 1, BASE + 32'(4 * MW), 4'hF, '0, 0, '0, 1); tick();

    wait_free(1, 1);
    issue(1, 0, BASE + 32'h30, 4'hF, 32'h0BAD_F00D, 0, '0, 0);
    tick();
    nrst = 1'b0;
    model_reset();
    tick();
    tick();
    nrst = 1'b1;
    tick();
    issue(1, 1, BASE + 32'h30, 4'hF, '0, 1, BASE + 32'h30, 1); tick();

    for (int k = 0; k < 600; k++) begin
      bit dd, di;
      dd = d_free() && ($urandom_range(0, 2) != 0);
      di = i_free() && ($urandom_range(0, 2) != 0);
      issue(dd, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom, di, rand_addr(), 1);
      tick();
    end

    wait_free(1, 1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
